// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl
// Drives the duty and prescaler inputs of one PWM channel so that the channel
// breathes: the duty climbs from a floor to a ceiling and back again in fixed
// steps, each level held for a programmable number of clocks. A host loads the
// ramp profile over a valid/ready port while the block is idle, then pulses
// start. The ramp runs once (ending with a done pulse) or repeats until stop.

module pwm_fade_ctrl #(
    parameter int R  = 10,
    parameter int TW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [31:0]   cfg_dvsr,
    input  logic [R:0]    cfg_min,
    input  logic [R:0]    cfg_max,
    input  logic [R:0]    cfg_step,
    input  logic [TW-1:0] cfg_tick,
    input  logic          cfg_loop,
    input  logic          start,
    input  logic          stop,
    output logic [R:0]    duty,
    output logic [31:0]   dvsr,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } state_t;

    // 2^R is full-on; the extra duty bit exists only to represent it
    localparam logic [R:0]    FULL_SCALE = {1'b1, {R{1'b0}}};
    localparam logic [R:0]    DUTY_ONE   = {{R{1'b0}}, 1'b1};
    localparam logic [TW-1:0] TICK_ONE   = {{(TW-1){1'b0}}, 1'b1};

    state_t        state_q;
    logic [R:0]    duty_q;
    logic [31:0]   dvsr_q;
    logic          busy_q;
    logic          done_q;
    logic [R:0]    min_q;
    logic [R:0]    max_q;
    logic [R:0]    step_q;
    logic [TW-1:0] tick_q;
    logic          loop_q;
    logic [TW-1:0] tickCnt_q;

    logic          cfgAccept;
    logic [R:0]    sanMax;
    logic [R:0]    sanMin;
    logic [R:0]    sanStep;
    logic [TW-1:0] sanTick;
    logic [R:0]    startDuty;
    logic          tickDone;
    logic [TW-1:0] tickCnt_d;
    logic [R+1:0]  upSum;
    logic [R+1:0]  downFloor;

    // The host may only hand over a profile while no ramp is running
    assign cfgAccept = cfg_valid && (state_q == IDLE);
    assign cfg_ready = (state_q == IDLE);

    assign duty = duty_q;
    assign dvsr = dvsr_q;
    assign busy = busy_q;
    assign done = done_q;

    // Clean up the incoming profile so the ramp can never overshoot or stall,
    // and work out the step arithmetic one bit wider so nothing wraps
    always_comb begin
        sanMax    = (cfg_max > FULL_SCALE) ? FULL_SCALE : cfg_max;
        sanMin    = (cfg_min > sanMax) ? sanMax : cfg_min;
        sanStep   = (cfg_step == '0) ? DUTY_ONE : cfg_step;
        sanTick   = (cfg_tick == '0) ? TICK_ONE : cfg_tick;
        startDuty = cfgAccept ? sanMin : min_q;
        tickDone  = (tickCnt_q == (tick_q - TICK_ONE));
        tickCnt_d = tickDone ? '0 : (tickCnt_q + TICK_ONE);
        upSum     = {1'b0, duty_q} + {1'b0, step_q};
        downFloor = {1'b0, min_q} + {1'b0, step_q};
    end

    // Ramp sequencer: profile latch, tick timing and the up/down walk of duty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            duty_q    <= '0;
            dvsr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            min_q     <= '0;
            max_q     <= FULL_SCALE;
            step_q    <= DUTY_ONE;
            tick_q    <= TICK_ONE;
            loop_q    <= 1'b0;
            tickCnt_q <= '0;
        end else begin
            done_q <= 1'b0;

            if (cfgAccept) begin
                min_q  <= sanMin;
                max_q  <= sanMax;
                step_q <= sanStep;
                tick_q <= sanTick;
                loop_q <= cfg_loop;
                dvsr_q <= cfg_dvsr;
            end

            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_q   <= UP;
                        busy_q    <= 1'b1;
                        duty_q    <= startDuty;
                        tickCnt_q <= '0;
                    end
                end

                UP: begin
                    if (stop) begin
                        state_q   <= IDLE;
                        duty_q    <= '0;
                        busy_q    <= 1'b0;
                        tickCnt_q <= '0;
                    end else begin
                        tickCnt_q <= tickCnt_d;
                        if (tickDone) begin
                            if (upSum >= {1'b0, max_q}) begin
                                duty_q  <= max_q;
                                state_q <= DOWN;
                            end else begin
                                duty_q <= upSum[R:0];
                            end
                        end
                    end
                end

                DOWN: begin
                    if (stop) begin
                        state_q   <= IDLE;
                        duty_q    <= '0;
                        busy_q    <= 1'b0;
                        tickCnt_q <= '0;
                    end else begin
                        tickCnt_q <= tickCnt_d;
                        if (tickDone) begin
                            if ({1'b0, duty_q} <= downFloor) begin
                                duty_q <= min_q;
                                if (loop_q) begin
                                    state_q <= UP;
                                end else begin
                                    state_q <= IDLE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end
                            end else begin
                                duty_q <= duty_q - step_q;
                            end
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl
// Bench for the fade sequencer. A reference model expands every started ramp
// into its list of duty levels and replays that list, one level per tick
// period; a compare process checks every output against it on each falling
// edge. Directed scenarios add literal expectations, then random traffic runs.

module tb_pwm_fade_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_dvsr;
    logic [10:0] cfg_min;
    logic [10:0] cfg_max;
    logic [10:0] cfg_step;
    logic [31:0] cfg_tick;
    logic        cfg_loop;
    logic        start;
    logic        stop;
    logic [10:0] duty;
    logic [31:0] dvsr;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          pMin, pMax, pStep, pTick;
    bit          pLoop;
    logic [31:0] mDvsr;
    bit          mActive;
    int          mIdx, mHold;
    int          mDuty;
    bit          mBusy, mDone;
    int          mLevels[$];

    pwm_fade_ctrl #(.R(10), .TW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_dvsr  (cfg_dvsr),
        .cfg_min   (cfg_min),
        .cfg_max   (cfg_max),
        .cfg_step  (cfg_step),
        .cfg_tick  (cfg_tick),
        .cfg_loop  (cfg_loop),
        .start     (start),
        .stop      (stop),
        .duty      (duty),
        .dvsr      (dvsr),
        .busy      (busy),
        .done      (done)
    );

    // free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        pMin    = 0;
        pMax    = 1024;
        pStep   = 1;
        pTick   = 1;
        pLoop   = 1'b0;
        mDvsr   = '0;
        mActive = 1'b0;
        mIdx    = 0;
        mHold   = 0;
        mDuty   = 0;
        mBusy   = 1'b0;
        mDone   = 1'b0;
        mLevels.delete();
    endtask

    // expand the stored profile into the full triangle: climb to max, fall to min
    task automatic buildLevels();
        int l;
        mLevels.delete();
        l = pMin;
        mLevels.push_back(l);
        forever begin
            if (l + pStep >= pMax) begin
                l = pMax;
                mLevels.push_back(l);
                break;
            end
            l = l + pStep;
            mLevels.push_back(l);
        end
        forever begin
            if (l <= pMin + pStep) begin
                mLevels.push_back(pMin);
                break;
            end
            l = l - pStep;
            mLevels.push_back(l);
        end
    endtask

    task automatic modelStep();
        int mx;
        mDone = 1'b0;
        if (mActive) begin
            if (stop) begin
                mActive = 1'b0;
                mBusy   = 1'b0;
                mDuty   = 0;
            end else begin
                mHold++;
                if (mHold == pTick) begin
                    mHold = 0;
                    mIdx++;
                    if (mIdx == mLevels.size() - 1) begin
                        if (pLoop) begin
                            mIdx = 0;
                        end else begin
                            mActive = 1'b0;
                            mBusy   = 1'b0;
                            mDone   = 1'b1;
                        end
                    end
                    mDuty = mLevels[mIdx];
                end
            end
        end else begin
            if (cfg_valid) begin
                mx    = int'(cfg_max);
                if (mx > 1024) mx = 1024;
                pMax  = mx;
                pMin  = (int'(cfg_min) > mx) ? mx : int'(cfg_min);
                pStep = (cfg_step == 0) ? 1 : int'(cfg_step);
                pTick = (cfg_tick == 0) ? 1 : int'(cfg_tick);
                pLoop = cfg_loop;
                mDvsr = cfg_dvsr;
            end
            if (start && !stop) begin
                buildLevels();
                mActive = 1'b1;
                mBusy   = 1'b1;
                mIdx    = 0;
                mHold   = 0;
                mDuty   = mLevels[0];
            end
        end
    endtask

    // advance the model on every rising edge outside reset
    always @(posedge clk) begin
        if (!reset) modelStep();
    end

    // compare every output against the model away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("duty", 32'(duty), 32'(mDuty));
            checkOutput("dvsr", dvsr, mDvsr);
            checkOutput("busy", 32'(busy), 32'(mBusy));
            checkOutput("done", 32'(done), 32'(mDone));
            checkOutput("cfg_ready", 32'(cfg_ready), 32'(!mActive));
        end
    end

    // drive one cycle of inputs, return at the next falling edge with pulses cleared
    task automatic applyStimulus(input bit v, input logic [31:0] dv, input int mn, input int mx,
                                 input int st, input logic [31:0] tk, input bit lp,
                                 input bit s, input bit sp);
        cfg_valid = v;
        cfg_dvsr  = dv;
        cfg_min   = 11'(mn);
        cfg_max   = 11'(mx);
        cfg_step  = 11'(st);
        cfg_tick  = tk;
        cfg_loop  = lp;
        start     = s;
        stop      = sp;
        @(negedge clk);
        cfg_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
    endtask

    task automatic pulseStart();
        applyStimulus(1'b0, 32'd0, 0, 0, 0, 32'd0, 1'b0, 1'b1, 1'b0);
    endtask

    // bound on total run time
    initial begin
        #600000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_dvsr  = '0;
        cfg_min   = '0;
        cfg_max   = '0;
        cfg_step  = '0;
        cfg_tick  = '0;
        cfg_loop  = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_duty", 32'(duty), 32'd0);
        checkOutput("rst_ready", 32'(cfg_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_dvsr", dvsr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // basic one-shot triangle
        applyStimulus(1'b1, 32'd33, 0, 1024, 256, 32'd4, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_dvsr", dvsr, 32'd33);
        pulseStart();
        checkOutput("t1_busy_start", 32'(busy), 32'd1);
        checkOutput("t1_duty_start", 32'(duty), 32'd0);
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (i == 3)  checkOutput("t1_duty_hold", 32'(duty), 32'd0);
            if (i == 4)  checkOutput("t1_duty_4", 32'(duty), 32'd256);
            if (i == 16) checkOutput("t1_duty_16", 32'(duty), 32'd1024);
            if (i == 20) checkOutput("t1_duty_20", 32'(duty), 32'd768);
            if (i == 31) checkOutput("t1_done_early", 32'(done), 32'd0);
            if (i == 31) checkOutput("t1_duty_31", 32'(duty), 32'd256);
        end
        checkOutput("t1_done", 32'(done), 32'd1);
        checkOutput("t1_busy_end", 32'(busy), 32'd0);
        checkOutput("t1_duty_end", 32'(duty), 32'd0);
        checkOutput("t1_dvsr_end", dvsr, 32'd33);
        @(negedge clk);
        checkOutput("t1_done_pulse", 32'(done), 32'd0);

        // saturation at max, then clamping of out-of-range fields
        applyStimulus(1'b1, 32'd5, 0, 1000, 300, 32'd2, 1'b0, 1'b0, 1'b0);
        pulseStart();
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 6)  checkOutput("t2_duty_900", 32'(duty), 32'd900);
            if (i == 8)  checkOutput("t2_duty_max", 32'(duty), 32'd1000);
            if (i == 10) checkOutput("t2_duty_700", 32'(duty), 32'd700);
        end
        checkOutput("t2_done", 32'(done), 32'd1);
        applyStimulus(1'b1, 32'd6, 1020, 1100, 0, 32'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("t2_clamp_start", 32'(duty), 32'd1020);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) checkOutput("t2_step1", 32'(duty), 32'd1021);
            if (i == 4) checkOutput("t2_clamp_max", 32'(duty), 32'd1024);
            if (i == 5) checkOutput("t2_clamp_down", 32'(duty), 32'd1023);
        end
        checkOutput("t2_clamp_done", 32'(done), 32'd1);

        // continuous mode, then stop while falling
        applyStimulus(1'b1, 32'd7, 100, 400, 100, 32'd3, 1'b1, 1'b0, 1'b0);
        pulseStart();
        for (int i = 1; i <= 31; i++) begin
            @(negedge clk);
            if (i == 9)  checkOutput("t3_duty_400", 32'(duty), 32'd400);
            if (i == 12) checkOutput("t3_duty_300", 32'(duty), 32'd300);
            if (i == 18) checkOutput("t3_wrap", 32'(duty), 32'd100);
            if (i == 18) checkOutput("t3_no_done", 32'(done), 32'd0);
            if (i == 21) checkOutput("t3_duty_200", 32'(duty), 32'd200);
            if (i == 31) checkOutput("t3_duty_down", 32'(duty), 32'd300);
        end
        applyStimulus(1'b0, 32'd0, 0, 0, 0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("t3_stop_duty", 32'(duty), 32'd0);
        checkOutput("t3_stop_busy", 32'(busy), 32'd0);
        checkOutput("t3_stop_done", 32'(done), 32'd0);

        // configuration offered while a ramp is running
        applyStimulus(1'b1, 32'd33, 0, 1024, 256, 32'd4, 1'b0, 1'b0, 1'b0);
        pulseStart();
        @(negedge clk);
        @(negedge clk);
        checkOutput("t4_ready_busy", 32'(cfg_ready), 32'd0);
        applyStimulus(1'b1, 32'd99, 0, 50, 10, 32'd1, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_dvsr_kept", dvsr, 32'd33);
        for (int i = 4; i <= 32; i++) begin
            @(negedge clk);
            if (i == 4) checkOutput("t4_ramp_kept", 32'(duty), 32'd256);
        end
        checkOutput("t4_done", 32'(done), 32'd1);
        applyStimulus(1'b1, 32'd99, 0, 50, 10, 32'd1, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_dvsr_new", dvsr, 32'd99);
        applyStimulus(1'b1, 32'd12, 200, 600, 200, 32'd2, 1'b0, 1'b1, 1'b0);
        checkOutput("t4_start_cfg_duty", 32'(duty), 32'd200);
        checkOutput("t4_start_cfg_dvsr", dvsr, 32'd12);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 4) checkOutput("t4_new_max", 32'(duty), 32'd600);
        end
        checkOutput("t4_new_done", 32'(done), 32'd1);

        // start and stop together, and start while busy
        applyStimulus(1'b0, 32'd0, 0, 0, 0, 32'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("t5_idle_busy", 32'(busy), 32'd0);
        checkOutput("t5_idle_duty", 32'(duty), 32'd200);
        applyStimulus(1'b1, 32'd12, 200, 600, 200, 32'd4, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("t5_duty_400", 32'(duty), 32'd400);
        pulseStart();
        checkOutput("t5_no_restart", 32'(duty), 32'd400);
        applyStimulus(1'b0, 32'd0, 0, 0, 0, 32'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("t5_abort_busy", 32'(busy), 32'd0);
        checkOutput("t5_abort_duty", 32'(duty), 32'd0);
        checkOutput("t5_abort_ready", 32'(cfg_ready), 32'd1);

        // asynchronous reset in the falling half, then default profile
        applyStimulus(1'b1, 32'd44, 0, 1024, 256, 32'd4, 1'b0, 1'b1, 1'b0);
        repeat (22) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("t6_rst_duty", 32'(duty), 32'd0);
        checkOutput("t6_rst_dvsr", dvsr, 32'd0);
        checkOutput("t6_rst_busy", 32'(busy), 32'd0);
        checkOutput("t6_rst_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        pulseStart();
        checkOutput("t6_def_start", 32'(duty), 32'd0);
        for (int i = 1; i <= 2048; i++) begin
            @(negedge clk);
            if (i == 1)    checkOutput("t6_def_1", 32'(duty), 32'd1);
            if (i == 1024) checkOutput("t6_def_top", 32'(duty), 32'd1024);
            if (i == 1025) checkOutput("t6_def_down", 32'(duty), 32'd1023);
        end
        checkOutput("t6_def_done", 32'(done), 32'd1);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom % 4) == 0, $urandom,
                          int'($urandom_range(0, 1100)), int'($urandom_range(0, 1100)),
                          int'($urandom_range(0, 300)), 32'($urandom_range(0, 4)),
                          bit'($urandom % 2), ($urandom % 8) == 0, ($urandom % 50) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
